// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer control/status bundle
// Purpose : groups the program-start, op stream and status signals of pc_sequencer.
// Ports   : master drives Start/StartAddr/Stall/Op/Flag/Target and observes
//           ProgCtr/Running/Done/Err/Depth; slave is the sequencer side.
interface pc_sequencer_if #(
    parameter int PW    = 10,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic          Start;
    logic [PW-1:0] StartAddr;
    logic          Stall;
    logic [2:0]    Op;
    logic          Flag;
    logic [PW-1:0] Target;
    logic [PW-1:0] ProgCtr;
    logic          Running;
    logic          Done;
    logic          Err;
    logic [DW-1:0] Depth;

    modport master (
        output Start, StartAddr, Stall, Op, Flag, Target,
        input  ProgCtr, Running, Done, Err, Depth
    );

    modport slave (
        input  Start, StartAddr, Stall, Op, Flag, Target,
        output ProgCtr, Running, Done, Err, Depth
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with optional return stack
// Purpose : IDLE/RUN/HALT sequencer applying NEXT/JABS/BREL/CALL/RET/HALT ops
//           to a PW-bit program counter, with a sticky fault flag.
// Ports   : Clk, ResetN (async active-low), bus (pc_sequencer_if.slave).
// Config  : PCSEQ_RET_STACK_EN defined -> DEPTH-entry return stack, CALL/RET legal;
//           undefined -> no stack, CALL/RET fault, Depth tied to 0.
module pc_sequencer #(
    parameter int PW    = 10,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         ResetN,
    pc_sequencer_if.slave bus
);
    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JABS = 3'd1;
    localparam logic [2:0] OP_BREL = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pc, w_pc_nxt;
    logic          r_err, w_err_nxt;
    logic          w_fault;

`ifdef PCSEQ_RET_STACK_EN
    localparam int             DW   = $clog2(DEPTH + 1);
    localparam int             AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0]  FULL = DW'(DEPTH);

    logic [PW-1:0] r_stack [DEPTH];
    logic [DW-1:0] r_depth, w_depth_nxt, w_top;
    logic          w_push;

    assign w_top = r_depth - DW'(1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_err;
        w_fault     = 1'b0;
`ifdef PCSEQ_RET_STACK_EN
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
`endif
        if (bus.Start) begin
            w_pc_nxt    = bus.StartAddr;
            w_err_nxt   = 1'b0;
            w_state_nxt = S_RUN;
`ifdef PCSEQ_RET_STACK_EN
            w_depth_nxt = '0;
`endif
        end else if (r_state == S_RUN && !bus.Stall) begin
            case (bus.Op)
                OP_NEXT: w_pc_nxt = r_pc + PW'(1);
                OP_JABS: w_pc_nxt = bus.Target;
                // A PW-bit add of the raw offset is the signed, wrapping add.
                OP_BREL: w_pc_nxt = bus.Flag ? (r_pc + bus.Target) : (r_pc + PW'(1));
`ifdef PCSEQ_RET_STACK_EN
                OP_CALL: begin
                    if (r_depth == FULL) begin
                        w_fault = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_pc_nxt    = bus.Target;
                        w_depth_nxt = r_depth + DW'(1);
                    end
                end
                OP_RET: begin
                    if (r_depth == '0) begin
                        w_fault = 1'b1;
                    end else begin
                        w_pc_nxt    = r_stack[w_top[AW-1:0]];
                        w_depth_nxt = w_top;
                    end
                end
`endif
                OP_HALT: w_state_nxt = S_HALT;
                default: w_fault = 1'b1;
            endcase
            // Faults leave PC and stack untouched; only the flag and state move.
            if (w_fault) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_HALT;
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_err   <= 1'b0;
`ifdef PCSEQ_RET_STACK_EN
            r_depth <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_err   <= w_err_nxt;
`ifdef PCSEQ_RET_STACK_EN
            r_depth <= w_depth_nxt;
`endif
        end
    end

`ifdef PCSEQ_RET_STACK_EN
    // Stack contents need no reset: entries above Depth are never read.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_stack[r_depth[AW-1:0]] <= r_pc + PW'(1);
        end
    end

    assign bus.Depth = r_depth;
`else
    assign bus.Depth = {$clog2(DEPTH + 1){1'b0}};
`endif

    assign bus.ProgCtr = r_pc;
    assign bus.Err     = r_err;
    assign bus.Running = (r_state == S_RUN);
    assign bus.Done    = (r_state == S_HALT);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int PW    = 10;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << PW) - 1;
`ifdef PCSEQ_RET_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic Clk = 1'b0;
    logic ResetN = 1'b1;
    always #5 Clk = ~Clk;

    pc_sequencer_if #(.PW(PW), .DEPTH(DEPTH)) bus ();

    pc_sequencer #(.PW(PW), .DEPTH(DEPTH)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 run, 2 halt; return stack as a queue.
    int m_pc;
    int m_mode;
    bit m_err;
    int m_stk[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".pc"},   32'(bus.ProgCtr), 32'(m_pc));
        chk({tag, ".run"},  32'(bus.Running), 32'(m_mode == 1));
        chk({tag, ".done"}, 32'(bus.Done),    32'(m_mode == 2));
        chk({tag, ".err"},  32'(bus.Err),     32'(m_err));
        chk({tag, ".dep"},  32'(bus.Depth),   32'(m_stk.size()));
    endtask

    task automatic m_reset();
        m_pc = 0; m_mode = 0; m_err = 1'b0; m_stk.delete();
    endtask

    task automatic m_clock();
        int op, tgt, off;
        bit fault;
        op = int'(bus.Op);
        tgt = int'(bus.Target);
        fault = 1'b0;
        if (bus.Start) begin
            m_pc = int'(bus.StartAddr); m_stk.delete(); m_err = 1'b0; m_mode = 1;
        end else if (m_mode == 1 && !bus.Stall) begin
            case (op)
                0: m_pc = (m_pc + 1) & MASK;
                1: m_pc = tgt;
                2: begin
                    off = ((tgt >> (PW - 1)) & 1) ? tgt - (1 << PW) : tgt;
                    m_pc = bus.Flag ? ((m_pc + off) & MASK) : ((m_pc + 1) & MASK);
                end
                3: if (!STK || m_stk.size() == DEPTH) fault = 1'b1;
                   else begin m_stk.push_back((m_pc + 1) & MASK); m_pc = tgt; end
                4: if (!STK || m_stk.size() == 0) fault = 1'b1;
                   else m_pc = m_stk.pop_back();
                5: m_mode = 2;
                default: fault = 1'b1;
            endcase
            if (fault) begin m_err = 1'b1; m_mode = 2; end
        end
    endtask

    task automatic drive(input bit st, input int addr, input bit stall,
                         input int op, input bit flag, input int tgt);
        bus.Start     = st;
        bus.StartAddr = PW'(addr);
        bus.Stall     = stall;
        bus.Op        = 3'(op);
        bus.Flag      = flag;
        bus.Target    = PW'(tgt);
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        m_clock();
        #1;
        compare_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        ResetN = 1'b0;
        #1;
        m_reset();
        compare_all(tag);
        #1 ResetN = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        #1 ResetN = 1'b0;
        #1;
        m_reset();
        compare_all("reset");
        repeat (2) @(posedge Clk);
        #1 ResetN = 1'b1;

        // Start + three NEXTs
        drive(1, 'h040, 0, 0, 0, 0); step("start40");
        chk("start40.const", 32'(bus.ProgCtr), 32'h040);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("next");
        chk("next3.const", 32'(bus.ProgCtr), 32'h043);
        chk("next3.running", 32'(bus.Running), 32'd1);

        // Wrap and BREL
        drive(1, 'h3FF, 0, 0, 0, 0); step("st3ff");
        drive(0, 0, 0, 0, 0, 0);     step("wrap");
        chk("wrap.const", 32'(bus.ProgCtr), 32'h000);
        chk("wrap.err", 32'(bus.Err), 32'd0);
        drive(1, 'h005, 0, 0, 0, 0); step("st5a");
        drive(0, 0, 0, 2, 1, 'h3FE); step("brel_t");
        chk("brel_t.const", 32'(bus.ProgCtr), 32'h003);
        drive(1, 'h005, 0, 0, 0, 0); step("st5b");
        drive(0, 0, 0, 2, 0, 'h3FE); step("brel_nt");
        chk("brel_nt.const", 32'(bus.ProgCtr), 32'h006);

`ifdef PCSEQ_RET_STACK_EN
        drive(1, 'h010, 0, 0, 0, 0); step("st10");
        drive(0, 0, 0, 3, 0, 'h100); step("call1");
        chk("call1.const", 32'(bus.ProgCtr), 32'h100);
        drive(0, 0, 0, 3, 0, 'h200); step("call2");
        chk("call2.dep", 32'(bus.Depth), 32'd2);
        drive(0, 0, 0, 4, 0, 0);     step("ret1");
        chk("ret1.const", 32'(bus.ProgCtr), 32'h101);
        step("ret2");
        chk("ret2.const", 32'(bus.ProgCtr), 32'h011);
        chk("ret2.dep", 32'(bus.Depth), 32'd0);
        // Overflow on fifth nested call
        drive(1, 0, 0, 0, 0, 0); step("st0");
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 3, 0, i * 'h40);
            step("ncall");
        end
        chk("ovf.err", 32'(bus.Err), 32'd1);
        chk("ovf.pc", 32'(bus.ProgCtr), 32'h100);
        // Underflow
        drive(1, 'h020, 0, 0, 0, 0); step("st20");
        drive(0, 0, 0, 4, 0, 0);     step("unf");
        chk("unf.done", 32'(bus.Done), 32'd1);
`else
        drive(1, 'h010, 0, 0, 0, 0); step("st10");
        drive(0, 0, 0, 3, 0, 'h100); step("call_ill");
        chk("call_ill.err", 32'(bus.Err), 32'd1);
        chk("call_ill.pc", 32'(bus.ProgCtr), 32'h010);
`endif

        // Illegal op, HALT op, ops ignored in HALT
        drive(1, 'h030, 0, 0, 0, 0); step("st30");
        drive(0, 0, 0, 6, 0, 0);     step("ill6");
        chk("ill6.err", 32'(bus.Err), 32'd1);
        drive(1, 'h031, 0, 0, 0, 0); step("st31");
        drive(0, 0, 0, 5, 0, 0);     step("haltop");
        drive(0, 0, 0, 1, 0, 'h155); step("haltign");
        chk("haltign.pc", 32'(bus.ProgCtr), 32'h031);

        // Stall holds, Start beats Stall
        drive(1, 'h123, 0, 0, 0, 0); step("st123");
        drive(0, 0, 1, 1, 0, 'h2AA);
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.const", 32'(bus.ProgCtr), 32'h123);
        drive(1, 'h077, 1, 1, 0, 'h2AA); step("ststall");
        chk("ststall.const", 32'(bus.ProgCtr), 32'h077);

        // Async reset between edges
        drive(0, 0, 0, 0, 0, 0); step("prerst");
        pulse_reset("midrst");
        chk("midrst.pc", 32'(bus.ProgCtr), 32'h000);
        step("postrst");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(15) == 0), int'($urandom_range(MASK)),
                  ($urandom_range(7) == 0),
                  ($urandom_range(9) == 0) ? int'($urandom_range(7)) : int'($urandom_range(4)),
                  1'($urandom_range(1)), int'($urandom_range(MASK)));
            if ($urandom_range(99) == 0) pulse_reset("rnd_rst");
            else step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PW, default 10, program counter width in bits (range 4..32).
REQ-002 SHALL have parameter DEPTH, default 4, return-address stack entries (range 1..16).
REQ-003 Clk  input  1  single clock; all state changes on rising edge only.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  begin program; load StartAddr.
REQ-006 StartAddr  input  PW  entry address of the program to run.
REQ-007 Stall  input  1  hold all state this cycle.
REQ-008 Op  input  3  sequencing op: 0 NEXT, 1 JABS, 2 BREL, 3 CALL, 4 RET, 5 HALT, 6-7 illegal.
REQ-009 Flag  input  1  ALU condition for BREL.
REQ-010 Target  input  PW  absolute address (JABS, CALL) or two's-complement offset (BREL).
REQ-011 ProgCtr  output  PW  current program counter.
REQ-012 Running  output  1  high in RUN state.
REQ-013 Done  output  1  high in HALT state.
REQ-014 Err  output  1  sticky fault flag.
REQ-015 Depth  output  $clog2(DEPTH+1)  current stack occupancy.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT; Running/Done decode state combinationally.
REQ-017 Start high in any state SHALL, next edge: ProgCtr<=StartAddr, stack emptied, Err<=0, state<=RUN; Start has priority over Stall and Op.
REQ-018 In IDLE and HALT without Start, ProgCtr, stack and Err SHALL hold; Op ignored.
REQ-019 In RUN with Stall high, all state SHALL hold; Op ignored.
REQ-020 In RUN, not stalled: NEXT -> ProgCtr+1; JABS -> Target; BREL -> ProgCtr+Target if Flag else ProgCtr+1.
REQ-021 CALL SHALL push ProgCtr+1 and load Target; RET SHALL pop top into ProgCtr.
REQ-022 All PC arithmetic SHALL be modulo 2^PW (wrap, no error); Target sign taken from bit PW-1 for BREL.
REQ-023 HALT op SHALL hold ProgCtr and move to HALT.
REQ-024 CALL with Depth==DEPTH (overflow), RET with Depth==0 (underflow), or Op 6/7 SHALL set Err, leave ProgCtr and stack unchanged, move to HALT.
REQ-025 Depth SHALL increment on successful CALL, decrement on successful RET, never exceed DEPTH.
REQ-026 Single-cycle latency: Op presented in cycle N is reflected in ProgCtr after edge N.

Reset
REQ-027 ResetN low SHALL immediately force ProgCtr=0, state=IDLE, Depth=0, Err=0, independent of Clk.
REQ-028 ResetN deassertion mid-program SHALL leave block in IDLE; stack contents are don't-care, Depth=0.
REQ-029 Reset SHALL dominate Start.

Configuration
REQ-030 Macro PCSEQ_RET_STACK_EN defined: stack, CALL, RET, Depth as above.
REQ-031 Macro undefined: no stack storage; CALL and RET treated as illegal ops (REQ-024); Depth tied to 0.

Verification
REQ-032 Reset, Start with StartAddr=0x040, 3x NEXT -> ProgCtr 0x040,0x041,0x042,0x043; Running=1.
REQ-033 ProgCtr=0x3FF (PW=10), NEXT -> 0x000, Err=0; BREL Target=0x3FE Flag=1 at 0x005 -> 0x003; Flag=0 -> 0x006.
REQ-034 (stack enabled, DEPTH=4) at 0x010 CALL 0x100, at 0x100 CALL 0x200, RET, RET -> 0x100,0x200,0x101,0x011; Depth 1,2,1,0.
REQ-035 Five nested CALLs -> fifth sets Err=1, Done=1, ProgCtr holds at 4th target; RET at Depth 0 -> Err=1, HALT.
REQ-036 Stall high 3 cycles with Op=JABS 0x2AA -> ProgCtr unchanged; Stall+Start together -> StartAddr loaded.
REQ-037 ResetN pulsed low between edges during RUN -> ProgCtr=0, IDLE, Err=0 before next edge; macro undefined, CALL -> Err=1.
